tx_byte_queue: RTL and testbench

Transmit-side byte queue between any byte producer (termbuffer, or a future command/status generator) and `uart_tx`. It is the send-direction counterpart of the `uart_rx` → termbuffer path. It accepts bytes with a one-cycle valid strobe and buffers them in a power-of-two FIFO. It releases them to `uart_tx` one frame at a time, pacing on `o_TX_Active` and `o_TX_Done`. It optionally expands LF to CR LF.

---
 rtl/tx_byte_queue.sv | 232 +++++++++++++++++++++++
 tb/tb_tx_byte_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_byte_queue.sv
// -----------------------------------------------------------------------------
// tx_byte_queue
//
// Transmit-side byte queue sitting between a byte producer and uart_tx.
// Bytes arrive with a one-cycle strobe and are held in a power-of-two FIFO.
// They leave one frame at a time. The queue paces itself on the
// uart_tx o_TX_Active / o_TX_Done handshake.
//
// Optional feature, selected at compile time with the macro TXQ_CRLF_EN:
//   When defined, every LF (0x0A) at the head is preceded on the line by a CR
//   (0x0D). The CR is inserted without consuming a queue entry.
//   When undefined, bytes pass through unchanged and no CR logic is built.
//
// Parameters
//   DEPTH        FIFO entries, power of two, >= 2
//   AW           pointer width, $clog2(DEPTH); count width is AW+1
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   i_byte       byte to enqueue
//   i_byte_v     one-cycle enqueue strobe
//   o_full       queue holds DEPTH entries
//   o_empty      queue holds no entries
//   o_count      number of entries held
//   o_overflow   sticky: a strobe arrived while full and was dropped
//   o_byte       byte presented to uart_tx i_TX_Byte (stable between frames)
//   o_byte_v     one-cycle start pulse to uart_tx i_TX_DV
//   i_tx_active  uart_tx o_TX_Active
//   i_tx_done    uart_tx o_TX_Done (may be held high for several cycles)
// -----------------------------------------------------------------------------
module tx_byte_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_v,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic [7:0]    o_byte,
  output logic          o_byte_v,
  input  logic          i_tx_active,
  input  logic          i_tx_done
);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
`ifdef TXQ_CRLF_EN
  localparam logic [7:0]    ASCII_LF  = 8'h0A;
  localparam logic [7:0]    ASCII_CR  = 8'h0D;
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];

  state_t        state_q,    state_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    byte_q,     byte_d;
`ifdef TXQ_CRLF_EN
  logic          cr_flag_q,  cr_flag_d;
`endif

  logic          full_q;
  logic          empty_q;
  logic          push;
  logic          pop;
  logic          link_quiet;
  logic [7:0]    head_byte;

  // Full/empty are decoded from the registered count, so a push in the same
  // cycle as a pop from a full queue is still judged against "full".
  assign full_q     = (count_q == FULL_CNT);
  assign empty_q    = (count_q == '0);
  assign push       = i_byte_v && !full_q;
  assign link_quiet = !i_tx_active && !i_tx_done;
  assign head_byte  = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FIFO write port. The array carries no reset; only the pointers do.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= i_byte;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state, frame byte selection, pop request
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    pop     = 1'b0;
`ifdef TXQ_CRLF_EN
    cr_flag_d = cr_flag_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only start a frame when uart_tx is fully idle. This also covers a
        // frame left running inside uart_tx across our own reset.
        if (!empty_q && link_quiet) begin
          state_d = ST_SEND;
`ifdef TXQ_CRLF_EN
          if ((head_byte == ASCII_LF) && !cr_flag_q) begin
            // Send a CR first and leave the LF at the head. The flag makes
            // the next start send the LF itself.
            byte_d    = ASCII_CR;
            cr_flag_d = 1'b1;
          end else begin
            byte_d    = head_byte;
            pop       = 1'b1;
            cr_flag_d = 1'b0;
          end
`else
          byte_d = head_byte;
          pop    = 1'b1;
`endif
        end
      end

      ST_SEND: begin
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        // Done may be held for more than one cycle. Wait for it to drop so a
        // long done pulse cannot launch a second frame.
        if (link_quiet) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointer, count and overflow next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // DEPTH is a power of two, so natural AW-bit wrap gives modulo DEPTH.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (i_byte_v && full_q) begin
      overflow_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      byte_q     <= byte_d;
    end
  end

`ifdef TXQ_CRLF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cr_flag_q <= 1'b0;
    end else begin
      cr_flag_q <= cr_flag_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_byte     = byte_q;
  assign o_byte_v   = (state_q == ST_SEND);

endmodule

// File: tb/tb_tx_byte_queue.sv
// -----------------------------------------------------------------------------
// tb_tx_byte_queue
//
// Bench for tx_byte_queue. A behavioural uart_tx stand-in and a queue-based
// reference of the byte stream live here. Directed phases run as one linear
// sequence: reset, single byte, burst/overflow, random wrap traffic, held done,
// reset mid-frame, and LF handling. Compile with +define+TXQ_CRLF_EN to
// exercise the CR insertion build.
// -----------------------------------------------------------------------------
module tb_tx_byte_queue;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    i_byte;
  logic          i_byte_v;
  logic          o_full;
  logic          o_empty;
  logic [AW:0]   o_count;
  logic          o_overflow;
  logic [7:0]    o_byte;
  logic          o_byte_v;
  logic          i_tx_active;
  logic          i_tx_done;

  always #5 clk = ~clk;

  tx_byte_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_byte      (i_byte),
    .i_byte_v    (i_byte_v),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_byte      (o_byte),
    .o_byte_v    (o_byte_v),
    .i_tx_active (i_tx_active),
    .i_tx_done   (i_tx_done)
  );

  int         checks = 0;
  int         errors = 0;

  // Reference: byte queue contents, sticky overflow, pending-CR flag.
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_cr;
  logic [7:0] last_out;
  logic [7:0] out_log[$];
  logic [7:0] acc[$];

  // uart_tx stand-in.
  int         u_busy;
  int         u_done;
  int         frame_len;
  int         done_hold;
  bit         force_busy;
  bit         prev_quiet;
  int         stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then update the reference
  // and compare at the falling edge.
  task automatic step(input logic v, input logic [7:0] b, input logic r);
    logic [7:0] exp_b;
    i_byte_v   = v;
    i_byte     = b;
    rst        = r;
    prev_quiet = !i_tx_active && !i_tx_done;
    @(posedge clk);
    @(negedge clk);

    if (r) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_cr     = 1'b0;
      last_out = 8'h00;
      stall    = 0;
    end else if (v) begin
      // Full is judged before any pop at the same edge.
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back(b);
    end

    if (o_byte_v) begin
      chk("issue_when_quiet", prev_quiet, 1);
      chk("issue_uart_idle", (u_busy == 0 && u_done == 0), 1);
      chk("issue_nonempty", (mq.size() != 0), 1);
      if (mq.size() != 0) begin
`ifdef TXQ_CRLF_EN
        if (mq[0] == 8'h0A && !m_cr) begin
          exp_b = 8'h0D;
          m_cr  = 1'b1;
        end else begin
          exp_b = mq.pop_front();
          m_cr  = 1'b0;
        end
`else
        exp_b = mq.pop_front();
`endif
        chk("o_byte", o_byte, exp_b);
      end
      last_out = o_byte;
      out_log.push_back(o_byte);
      u_busy = frame_len;
      stall  = 0;
    end else begin
      chk("o_byte_hold", o_byte, last_out);
      if (mq.size() != 0 && prev_quiet) stall++;
      else stall = 0;
      chk("no_stall", (stall <= 2), 1);
    end

    chk("o_count", o_count, mq.size());
    chk("o_empty", o_empty, (mq.size() == 0));
    chk("o_full", o_full, (mq.size() == DEPTH));
    chk("o_overflow", o_overflow, m_ovf);

    // Advance the uart_tx stand-in: active for frame_len cycles, then done
    // for done_hold cycles, then quiet.
    if (u_busy > 0) begin
      i_tx_active = 1'b1;
      i_tx_done   = 1'b0;
      u_busy--;
      if (u_busy == 0) u_done = done_hold;
    end else if (u_done > 0) begin
      i_tx_active = 1'b0;
      i_tx_done   = 1'b1;
      u_done--;
    end else begin
      i_tx_active = force_busy;
      i_tx_done   = 1'b0;
    end
    $display("t=%0t rst=%0b push=%0b/%02h out_v=%0b out=%02h count=%0d ovf=%0b act=%0b done=%0b",
             $time, r, v, b, o_byte_v, o_byte, o_count, o_overflow, i_tx_active, i_tx_done);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || u_busy != 0 || u_done != 0 || i_tx_active || i_tx_done) && n < 3000) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_in_budget", (n < 3000), 1);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    logic       rv;
    int         pushes;
    rst         = 1'b1;
    i_byte      = 8'h00;
    i_byte_v    = 1'b0;
    i_tx_active = 1'b0;
    i_tx_done   = 1'b0;
    u_busy      = 0;
    u_done      = 0;
    frame_len   = 6;
    done_hold   = 1;
    force_busy  = 1'b0;
    stall       = 0;
    last_out    = 8'h00;
    @(negedge clk);

    // Reset state.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("reset_o_byte", o_byte, 8'h00);
    chk("reset_o_byte_v", o_byte_v, 0);
    chk("reset_o_count", o_count, 0);
    chk("reset_o_empty", o_empty, 1);
    chk("reset_o_full", o_full, 0);
    chk("reset_o_overflow", o_overflow, 0);
    step(1'b0, 8'h00, 1'b0);

    // Single byte: issue two cycles after the push.
    step(1'b1, 8'h41, 1'b0);
    chk("single_count1", o_count, 1);
    chk("single_v_early", o_byte_v, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_v", o_byte_v, 1);
    chk("single_byte", o_byte, 8'h41);
    chk("single_count0", o_count, 0);
    chk("single_empty", o_empty, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("single_pulse_width", o_byte_v, 0);
    drain();

    // Burst while uart_tx is busy, then overflow.
    out_log.delete();
    force_busy = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b1, 8'(8'h30 + k), 1'b0);
    chk("burst_full", o_full, 1);
    chk("burst_count", o_count, 16);
    chk("burst_no_ovf", o_overflow, 0);
    step(1'b1, 8'h99, 1'b0);
    chk("ovf_set", o_overflow, 1);
    chk("ovf_count", o_count, 16);
    force_busy = 1'b0;
    drain();
    chk("burst_log_size", out_log.size(), 16);
    for (int k = 0; k < 16 && k < out_log.size(); k++)
      chk("burst_order", out_log[k], 8'(8'h30 + k));
    chk("ovf_sticky", o_overflow, 1);

    // Random traffic across the pointer wrap.
    out_log.delete();
    acc.delete();
    frame_len = 3;
    done_hold = 1;
    pushes    = 0;
    for (int c = 0; c < 3000 && pushes < 40; c++) begin
      rv = ($urandom_range(0, 3) == 0);
      rb = 8'($urandom);
      if (rb == 8'h0A) rb = 8'h0B;
      if (rv) begin
        pushes++;
        if (mq.size() < DEPTH) acc.push_back(rb);
      end
      step(rv, rb, 1'b0);
    end
    drain();
    chk("wrap_log_size", out_log.size(), acc.size());
    for (int k = 0; k < acc.size() && k < out_log.size(); k++)
      chk("wrap_order", out_log[k], acc[k]);

    // Done held for two cycles: one frame per byte.
    out_log.delete();
    frame_len = 4;
    done_hold = 2;
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h61 + k), 1'b0);
    drain();
    chk("done_held_log_size", out_log.size(), 5);
    for (int k = 0; k < 5 && k < out_log.size(); k++)
      chk("done_held_order", out_log[k], 8'(8'h61 + k));

    // Reset while a frame is in flight with three bytes queued.
    out_log.delete();
    frame_len = 20;
    done_hold = 1;
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h50 + k), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0);
    chk("rst_mid_count_before", o_count, 3);
    chk("rst_mid_ovf_before", o_overflow, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_mid_count", o_count, 0);
    chk("rst_mid_overflow", o_overflow, 0);
    chk("rst_mid_empty", o_empty, 1);
    frame_len = 3;
    step(1'b1, 8'h77, 1'b0);
    drain();
    chk("rst_mid_log_size", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("rst_mid_first", out_log[0], 8'h50);
      chk("rst_mid_new", out_log[1], 8'h77);
    end

    // LF handling.
    out_log.delete();
    step(1'b1, 8'h48, 1'b0);
    step(1'b1, 8'h0A, 1'b0);
    drain();
`ifdef TXQ_CRLF_EN
    chk("crlf_log_size", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("crlf_0", out_log[0], 8'h48);
      chk("crlf_1", out_log[1], 8'h0D);
      chk("crlf_2", out_log[2], 8'h0A);
    end
`else
    chk("lf_log_size", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("lf_0", out_log[0], 8'h48);
      chk("lf_1", out_log[1], 8'h0A);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
